// File: rtl/addr_reg_bank.sv
// Bank of address-width registers with byte/word loads, one-hot address bus drive,
// a relay-timed incrementer (src+1 -> dst) and LED mirrors of load/select strobes.
module addr_reg_bank #(
    parameter int unsigned NUM_REGS      = 4,
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned IDX_W         = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [ADDR_W-1:0]          addr_in,
    input  logic [NUM_REGS-1:0]        ld_lo,
    input  logic [NUM_REGS-1:0]        ld_hi,
    input  logic [NUM_REGS-1:0]        ld_full,
    input  logic [NUM_REGS-1:0]        sel,
    output logic [ADDR_W-1:0]          addr_out,
    output logic                       addr_oe,
    output logic                       sel_err,
    input  logic                       inc_req,
    input  logic [IDX_W-1:0]           inc_src,
    input  logic [IDX_W-1:0]           inc_dst,
    output logic                       inc_busy,
    output logic                       inc_done,
    output logic [NUM_REGS-1:0]        led_ld,
    output logic [NUM_REGS-1:0]        led_sel,
    output logic [NUM_REGS*ADDR_W-1:0] reg_flat
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StSettle, StWrite} inc_state_e;

    inc_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   res_q, res_d;
    logic [IDX_W-1:0]    dst_q, dst_d;
    logic                wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]   regs_q [NUM_REGS];
    logic [ADDR_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] led_ld_q, led_sel_q;

    logic [ADDR_W-1:0]   src_val;
    logic                src_ok, dst_ok;
    logic                sel_multi, sel_one;
    logic [ADDR_W-1:0]   addr_mux;

    // Index decode by comparison so out-of-range indices simply match nothing.
    always_comb begin
        src_val = '0;
        src_ok  = 1'b0;
        dst_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (inc_src == IDX_W'(i)) begin
                src_val = regs_q[i];
                src_ok  = 1'b1;
            end
            if (inc_dst == IDX_W'(i)) begin
                dst_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dst_d   = dst_q;
        wb_en_d = wb_en_q;
        unique case (state_q)
            StIdle: begin
                if (inc_req) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                    res_d   = (src_ok && dst_ok) ? src_val + ADDR_W'(1) : '0;
                    dst_d   = inc_dst;
                    wb_en_d = src_ok && dst_ok;
                end
            end
            StSettle: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // External loads always beat the incrementer writeback on the same register.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (ld_full[i]) begin
                regs_d[i] = addr_in;
            end else if (ld_hi[i] || ld_lo[i]) begin
                if (ld_hi[i]) regs_d[i][ADDR_W-1:DATA_W] = data_in;
                if (ld_lo[i]) regs_d[i][DATA_W-1:0] = data_in;
            end else if (state_q == StWrite && wb_en_q && dst_q == IDX_W'(i)) begin
                regs_d[i] = res_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            res_q     <= '0;
            dst_q     <= '0;
            wb_en_q   <= 1'b0;
            led_ld_q  <= '0;
            led_sel_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            dst_q     <= dst_d;
            wb_en_q   <= wb_en_d;
            led_ld_q  <= ld_lo | ld_hi | ld_full;
            led_sel_q <= sel;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        sel_multi = |(sel & (sel - NUM_REGS'(1)));
        sel_one   = (sel != '0) && !sel_multi;
        addr_mux  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) addr_mux = addr_mux | regs_q[i];
        end
    end

    always_comb begin
        reg_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_flat[i*ADDR_W +: ADDR_W] = regs_q[i];
        end
    end

    assign addr_out = sel_one ? addr_mux : '0;
    assign addr_oe  = sel_one;
    assign sel_err  = sel_multi;
    assign inc_busy = (state_q != StIdle);
    assign inc_done = (state_q == StWrite);
    assign led_ld   = led_ld_q;
    assign led_sel  = led_sel_q;

endmodule

// File: tb/tb_addr_reg_bank.sv
// Self-checking bench for addr_reg_bank: directed scenarios plus randomized traffic
// compared against a cycle-age behavioural model of the bank and incrementer.
`timescale 1ns/1ps
module tb_addr_reg_bank;

    localparam int S = 3;

    logic        clk;
    logic        reset_n;
    logic [7:0]  data_in;
    logic [15:0] addr_in;
    logic [3:0]  ld_lo, ld_hi, ld_full, sel;
    logic [15:0] addr_out;
    logic        addr_oe, sel_err;
    logic        inc_req;
    logic [1:0]  inc_src, inc_dst;
    logic        inc_busy, inc_done;
    logic [3:0]  led_ld, led_sel;
    logic [63:0] reg_flat;

    int n_tests = 0;
    int n_fail  = 0;

    addr_reg_bank #(
        .NUM_REGS(4), .DATA_W(8), .ADDR_W(16), .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .addr_in(addr_in),
        .ld_lo(ld_lo), .ld_hi(ld_hi), .ld_full(ld_full), .sel(sel),
        .addr_out(addr_out), .addr_oe(addr_oe), .sel_err(sel_err),
        .inc_req(inc_req), .inc_src(inc_src), .inc_dst(inc_dst),
        .inc_busy(inc_busy), .inc_done(inc_done), .led_ld(led_ld), .led_sel(led_sel),
        .reg_flat(reg_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: register contents plus the age (cycles since request) of a pending increment.
    logic [15:0] m_regs [4];
    logic [3:0]  m_led_ld, m_led_sel;
    int          m_age;
    logic [15:0] m_res;
    int          m_dst;

    function automatic logic [63:0] m_flat();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
        m_led_ld  = 4'h0;
        m_led_sel = 4'h0;
        m_age     = 0;
    endtask

    task model_edge();
        logic [15:0] nx [4];
        for (int i = 0; i < 4; i++) begin
            nx[i] = m_regs[i];
            if (ld_full[i]) nx[i] = addr_in;
            else begin
                if (ld_hi[i]) nx[i][15:8] = data_in;
                if (ld_lo[i]) nx[i][7:0] = data_in;
            end
        end
        if (m_age == S + 1) begin
            if (!(ld_full[m_dst] | ld_hi[m_dst] | ld_lo[m_dst])) nx[m_dst] = m_res;
            m_age = 0;
        end else if (m_age > 0) begin
            m_age++;
        end else if (inc_req) begin
            m_res = m_regs[inc_src] + 16'd1;
            m_dst = int'(inc_dst);
            m_age = 1;
        end
        for (int i = 0; i < 4; i++) m_regs[i] = nx[i];
        m_led_ld  = ld_lo | ld_hi | ld_full;
        m_led_sel = sel;
    endtask

    task idle_inputs();
        data_in = 8'h0; addr_in = 16'h0;
        ld_lo = 4'h0; ld_hi = 4'h0; ld_full = 4'h0; sel = 4'h0;
        inc_req = 1'b0; inc_src = 2'd0; inc_dst = 2'd0;
    endtask

    task step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task test_reset();
        data_in = 8'($urandom); addr_in = 16'($urandom);
        ld_lo = 4'($urandom); ld_hi = 4'($urandom); ld_full = 4'($urandom);
        sel = 4'($urandom); inc_req = 1'b1; inc_src = 2'($urandom); inc_dst = 2'($urandom);
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (reg_flat !== 64'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h want 0", reg_flat);
        end
        n_tests++;
        if (inc_busy !== 1'b0 || inc_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_inc: busy=%b done=%b want 0 0", inc_busy, inc_done);
        end
        n_tests++;
        if (led_ld !== 4'h0 || led_sel !== 4'h0) begin
            n_fail++; $display("FAIL reset_led: ld=%b sel=%b want 0", led_ld, led_sel);
        end
        sel = 4'h0;
        #1;
        n_tests++;
        if (addr_oe !== 1'b0 || addr_out !== 16'h0 || sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_addr: oe=%b out=%h err=%b want 0 0 0", addr_oe, addr_out, sel_err);
        end
        idle_inputs();
        #2;
        reset_n = 1'b1;
        step();
    endtask

    task test_byte_loads();
        idle_inputs(); ld_lo = 4'b0010; data_in = 8'h34;
        step();
        n_tests++;
        if (led_ld !== 4'b0010 || reg_flat[23:16] !== 8'h34) begin
            n_fail++; $display("FAIL byte_lo: led=%b lo=%h want 0010 34", led_ld, reg_flat[23:16]);
        end
        idle_inputs(); ld_hi = 4'b0010; data_in = 8'h12;
        step();
        n_tests++;
        if (led_ld !== 4'b0010 || reg_flat[31:16] !== 16'h1234) begin
            n_fail++; $display("FAIL byte_hi: led=%b r1=%h want 0010 1234", led_ld, reg_flat[31:16]);
        end
        idle_inputs(); sel = 4'b0010;
        #1;
        n_tests++;
        if (addr_out !== 16'h1234 || addr_oe !== 1'b1 || sel_err !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_sel: out=%h oe=%b err=%b want 1234 1 0", addr_out, addr_oe, sel_err);
        end
        idle_inputs();
    endtask

    task test_full_priority();
        idle_inputs(); ld_full = 4'b0100; addr_in = 16'hBEEF; ld_lo = 4'b0100; data_in = 8'h00;
        step();
        idle_inputs();
        n_tests++;
        if (reg_flat[47:32] !== 16'hBEEF) begin
            n_fail++; $display("FAIL full_prio: r2=%h want beef", reg_flat[47:32]);
        end
    endtask

    task test_increment();
        idle_inputs(); ld_full = 4'b0001; addr_in = 16'hFFFF;
        step();
        idle_inputs(); inc_req = 1'b1; inc_src = 2'd0; inc_dst = 2'd3;
        step();
        for (int k = 1; k <= 4; k++) begin
            n_tests++;
            if (inc_busy !== 1'b1 || inc_done !== (k == 4)) begin
                n_fail++;
                $display("FAIL inc_cycle%0d: busy=%b done=%b want 1 %b", k, inc_busy, inc_done, k == 4);
            end
            idle_inputs();
            if (k == 2) begin
                inc_req = 1'b1; inc_src = 2'd2; inc_dst = 2'd0;
            end
            step();
        end
        n_tests++;
        if (inc_busy !== 1'b0 || inc_done !== 1'b0) begin
            n_fail++; $display("FAIL inc_end: busy=%b done=%b want 0 0", inc_busy, inc_done);
        end
        n_tests++;
        if (reg_flat[63:48] !== 16'h0000 || reg_flat[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL inc_wrap: r3=%h r0=%h want 0000 ffff", reg_flat[63:48], reg_flat[15:0]);
        end
        repeat (S + 2) step();
        n_tests++;
        if (inc_busy !== 1'b0 || reg_flat[15:0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL inc_ignored: busy=%b r0=%h want 0 ffff", inc_busy, reg_flat[15:0]);
        end
    endtask

    task test_collision();
        idle_inputs(); inc_req = 1'b1; inc_src = 2'd0; inc_dst = 2'd3;
        step();
        idle_inputs();
        repeat (S) step();
        n_tests++;
        if (inc_done !== 1'b1) begin
            n_fail++; $display("FAIL coll_done: done=%b want 1", inc_done);
        end
        ld_full = 4'b1000; addr_in = 16'h5555;
        step();
        idle_inputs();
        n_tests++;
        if (reg_flat[63:48] !== 16'h5555 || inc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_reg: r3=%h done=%b want 5555 0", reg_flat[63:48], inc_done);
        end
    endtask

    task test_reset_abort();
        int seen_done;
        idle_inputs(); inc_req = 1'b1; inc_src = 2'd2; inc_dst = 2'd3;
        step();
        idle_inputs();
        step();
        reset_n = 1'b0;
        model_reset();
        seen_done = 0;
        for (int k = 0; k < S + 3; k++) begin
            #1;
            if (inc_done !== 1'b0 || inc_busy !== 1'b0) seen_done++;
            @(posedge clk);
        end
        #2;
        reset_n = 1'b1;
        for (int k = 0; k < S + 3; k++) begin
            step();
            if (inc_done !== 1'b0) seen_done++;
        end
        n_tests++;
        if (seen_done != 0) begin
            n_fail++; $display("FAIL abort_done: %0d cycles busy/done, want 0", seen_done);
        end
        n_tests++;
        if (reg_flat[63:48] !== 16'h0000) begin
            n_fail++; $display("FAIL abort_reg: r3=%h want 0000", reg_flat[63:48]);
        end
    endtask

    task test_select();
        logic [15:0] r;
        r = 16'($urandom_range(1, 16'hFFFF));
        idle_inputs(); ld_full = 4'b0100; addr_in = r;
        step();
        idle_inputs(); sel = 4'b0101;
        #1;
        n_tests++;
        if (sel_err !== 1'b1 || addr_oe !== 1'b0 || addr_out !== 16'h0) begin
            n_fail++;
            $display("FAIL sel_conflict: err=%b oe=%b out=%h want 1 0 0", sel_err, addr_oe, addr_out);
        end
        sel = 4'b0100;
        #1;
        n_tests++;
        if (sel_err !== 1'b0 || addr_oe !== 1'b1 || addr_out !== r) begin
            n_fail++;
            $display("FAIL sel_single: err=%b oe=%b out=%h want 0 1 %h", sel_err, addr_oe, addr_out, r);
        end
        idle_inputs();
    endtask

    task test_random();
        int          ones;
        logic [15:0] exp_out;
        for (int c = 0; c < 400; c++) begin
            data_in = 8'($urandom); addr_in = 16'($urandom);
            ld_lo   = 4'($urandom & $urandom & $urandom);
            ld_hi   = 4'($urandom & $urandom & $urandom);
            ld_full = 4'($urandom & $urandom & $urandom);
            case ($urandom_range(0, 3))
                0:       sel = 4'h0;
                1, 2:    sel = 4'(1 << $urandom_range(0, 3));
                default: sel = 4'($urandom);
            endcase
            inc_req = ($urandom_range(0, 3) == 0);
            inc_src = 2'($urandom); inc_dst = 2'($urandom);
            #1;
            ones = $countones(sel);
            exp_out = 16'h0;
            for (int i = 0; i < 4; i++) if (ones == 1 && sel[i]) exp_out = m_regs[i];
            n_tests++;
            if (addr_out !== exp_out || addr_oe !== (ones == 1) || sel_err !== (ones > 1)) begin
                n_fail++;
                $display("FAIL rnd_addr c%0d: out=%h oe=%b err=%b want %h %b %b", c, addr_out,
                         addr_oe, sel_err, exp_out, ones == 1, ones > 1);
            end
            step();
            n_tests++;
            if (reg_flat !== m_flat()) begin
                n_fail++; $display("FAIL rnd_regs c%0d: got %h want %h", c, reg_flat, m_flat());
            end
            n_tests++;
            if (inc_busy !== (m_age > 0) || inc_done !== (m_age == S + 1)) begin
                n_fail++;
                $display("FAIL rnd_inc c%0d: busy=%b done=%b want %b %b", c, inc_busy, inc_done,
                         m_age > 0, m_age == S + 1);
            end
            n_tests++;
            if (led_ld !== m_led_ld || led_sel !== m_led_sel) begin
                n_fail++;
                $display("FAIL rnd_led c%0d: ld=%b sel=%b want %b %b", c, led_ld, led_sel,
                         m_led_ld, m_led_sel);
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_byte_loads();
        test_full_priority();
        test_increment();
        test_collision();
        test_reset_abort();
        test_select();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
